// File: rtl/softusb_txseq_if.sv
// Handshake bundle between a packet controller and softusb_txseq: request side,
// packet buffer read port and the byte stream towards softusb_tx.
interface softusb_txseq_if #(
    parameter int AW = 6
);
    logic          start;
    logic [3:0]    pid;
    logic [AW:0]   len;
    logic          crc_en;
    logic          keepalive;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          txoe;
    logic          generate_eop;
    logic          busy;
    logic          done;
    logic          aborted;

    modport master (
        output start, pid, len, crc_en, keepalive, abort, rd_data, tx_ready, txoe,
        input  rd_addr, tx_data, tx_valid, generate_eop, busy, done, aborted
    );

    modport slave (
        input  start, pid, len, crc_en, keepalive, abort, rd_data, tx_ready, txoe,
        output rd_addr, tx_data, tx_valid, generate_eop, busy, done, aborted
    );
endinterface

// File: rtl/softusb_txseq.sv
// Packet transmit sequencer feeding softusb_tx: SYNC, PID, buffered payload and optional
// CRC16, then lets softusb_tx close with EOP; also issues stand-alone keep-alive EOPs.
module softusb_txseq #(
    parameter int AW = 6
) (
    input  logic           usb_clk,
    input  logic           usb_rst,
    softusb_txseq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRCL, S_CRCH, S_DRAIN, S_KEEP
    } state_t;

    localparam logic [AW:0]   LEN_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    state_t        state_q, state_d;
    logic [3:0]    pid_q, pid_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          crc_en_q, crc_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          generate_eop_q, generate_eop_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic          ka_pend_q, ka_pend_d;
    logic          abort_pend_q, abort_pend_d;
    logic          txoe_seen_q, txoe_seen_d;

    logic          accept;
    logic          in_packet;
    logic [15:0]   crc_next;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign accept    = tx_valid_q & bus.tx_ready;
    assign in_packet = state_q inside {S_SYNC, S_PID, S_DATA, S_CRCL, S_CRCH};
    assign crc_next  = crc16_byte(crc_q, tx_data_q);

    always_comb begin
        state_d        = state_q;
        pid_d          = pid_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        crc_en_d       = crc_en_q;
        rd_addr_d      = rd_addr_q;
        crc_d          = crc_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        generate_eop_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        aborted_d      = 1'b0;
        ka_pend_d      = ka_pend_q | bus.keepalive;
        abort_pend_d   = abort_pend_q;
        txoe_seen_d    = txoe_seen_q;

        if (in_packet) begin
            abort_pend_d = abort_pend_q | bus.abort;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pid_d        = bus.pid;
                    len_d        = bus.len;
                    crc_en_d     = bus.crc_en;
                    rd_addr_d    = '0;
                    cnt_d        = '0;
                    crc_d        = 16'hFFFF;
                    abort_pend_d = 1'b0;
                    tx_data_d    = 8'h80;
                    tx_valid_d   = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = S_SYNC;
                end else if (ka_pend_q && !bus.txoe) begin
                    generate_eop_d = 1'b1;
                    ka_pend_d      = bus.keepalive;
                    txoe_seen_d    = 1'b0;
                    state_d        = S_KEEP;
                end
            end
            S_KEEP: begin
                if (bus.txoe) begin
                    txoe_seen_d = 1'b1;
                end else if (txoe_seen_q) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!bus.txoe) begin
                    done_d       = 1'b1;
                    aborted_d    = abort_pend_q;
                    abort_pend_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                if (accept) begin
                    if (abort_pend_q || bus.abort) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_DRAIN;
                    end else begin
                        case (state_q)
                            S_SYNC: begin
                                tx_data_d = {~pid_q, pid_q};
                                state_d   = S_PID;
                            end
                            S_PID: begin
                                if (len_q != '0) begin
                                    // rd_addr runs one byte ahead so rd_data is settled before the next accept
                                    tx_data_d = bus.rd_data;
                                    rd_addr_d = rd_addr_q + ADDR_ONE;
                                    cnt_d     = '0;
                                    state_d   = S_DATA;
                                end else if (crc_en_q) begin
                                    tx_data_d = ~crc_q[7:0];
                                    state_d   = S_CRCL;
                                end else begin
                                    tx_valid_d = 1'b0;
                                    state_d    = S_DRAIN;
                                end
                            end
                            S_DATA: begin
                                crc_d = crc_next;
                                if (cnt_q == len_q - LEN_ONE) begin
                                    if (crc_en_q) begin
                                        tx_data_d = ~crc_next[7:0];
                                        state_d   = S_CRCL;
                                    end else begin
                                        tx_valid_d = 1'b0;
                                        state_d    = S_DRAIN;
                                    end
                                end else begin
                                    tx_data_d = bus.rd_data;
                                    rd_addr_d = rd_addr_q + ADDR_ONE;
                                    cnt_d     = cnt_q + LEN_ONE;
                                end
                            end
                            S_CRCL: begin
                                tx_data_d = ~crc_q[15:8];
                                state_d   = S_CRCH;
                            end
                            default: begin
                                tx_valid_d = 1'b0;
                                state_d    = S_DRAIN;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            state_q        <= S_IDLE;
            pid_q          <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            crc_en_q       <= 1'b0;
            rd_addr_q      <= '0;
            crc_q          <= 16'hFFFF;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            generate_eop_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            ka_pend_q      <= 1'b0;
            abort_pend_q   <= 1'b0;
            txoe_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pid_q          <= pid_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            crc_en_q       <= crc_en_d;
            rd_addr_q      <= rd_addr_d;
            crc_q          <= crc_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            generate_eop_q <= generate_eop_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            ka_pend_q      <= ka_pend_d;
            abort_pend_q   <= abort_pend_d;
            txoe_seen_q    <= txoe_seen_d;
        end
    end

    assign bus.rd_addr      = rd_addr_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.generate_eop = generate_eop_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
endmodule

// File: tb/tb_softusb_txseq.sv
// Scoreboard bench for softusb_txseq: a softusb_tx sink model, a registered-read packet buffer
// and a byte-list reference model of each packet.
module tb_softusb_txseq;
    localparam int AW   = 6;
    localparam int NBUF = 1 << AW;

    logic usb_clk = 1'b0;
    logic usb_rst = 1'b1;
    always #5 usb_clk = ~usb_clk;

    softusb_txseq_if #(.AW(AW)) bus ();
    softusb_txseq #(.AW(AW)) dut (.usb_clk(usb_clk), .usb_rst(usb_rst), .bus(bus.slave));

    typedef struct packed {
        logic aborted;
        logic crc;
    } done_exp_t;

    logic [7:0]  mem [NBUF];
    logic [7:0]  exp_q [$];
    done_exp_t   dexp_q [$];
    int          checks      = 0;
    int          fails       = 0;
    int          acc_cnt     = 0;
    int          done_cnt    = 0;
    int          eop_pulses  = 0;
    int          eop_at_done = 0;
    int          pkt_idx     = 0;
    logic [15:0] res_crc     = 16'hFFFF;

    // Reflected USB CRC16 one byte at a time, LSB first.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    // Packet buffer with one-cycle registered read.
    initial begin
        bus.rd_data = 8'h00;
        forever begin
            @(posedge usb_clk);
            bus.rd_data <= mem[bus.rd_addr];
        end
    end

    // softusb_tx sink: never ready twice in a row, txoe high from first accept through EOP.
    initial begin
        int eop_cnt, eop_len, ka_cnt;
        bit pkt_on, acc_prev;
        eop_cnt = 0; eop_len = 3; ka_cnt = 0; pkt_on = 0; acc_prev = 0;
        bus.tx_ready = 1'b0;
        bus.txoe     = 1'b0;
        forever begin
            @(posedge usb_clk); #1;
            if (usb_rst) begin
                bus.tx_ready = 1'b0; bus.txoe = 1'b0;
                pkt_on = 0; eop_cnt = 0; ka_cnt = 0; acc_prev = 0;
            end else begin
                if (acc_prev) begin
                    pkt_on = 1; eop_cnt = 0;
                end else if (pkt_on && !bus.tx_valid) begin
                    eop_cnt++;
                    if (eop_cnt >= eop_len) begin
                        pkt_on  = 0;
                        eop_len = $urandom_range(2, 5);
                    end
                end
                if (bus.generate_eop) ka_cnt = $urandom_range(2, 4);
                else if (ka_cnt > 0) ka_cnt--;
                bus.txoe     = pkt_on || (ka_cnt > 0);
                bus.tx_ready = bus.tx_valid && !bus.tx_ready && ($urandom_range(0, 2) != 0);
                acc_prev     = bus.tx_ready && bus.tx_valid;
            end
        end
    end

    // Monitor: pops expected bytes on each accept and expected completion on each done.
    initial begin
        logic [7:0] e;
        done_exp_t  de;
        forever begin
            @(negedge usb_clk);
            if (usb_rst) begin
                pkt_idx = 0; res_crc = 16'hFFFF;
            end else begin
                if (bus.tx_valid && bus.tx_ready) begin
                    acc_cnt++;
                    if (pkt_idx >= 2) res_crc = crc_ref(res_crc, bus.tx_data);
                    pkt_idx++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h, no byte expected", bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.tx_data !== e) begin
                            fails++;
                            $display("FAIL tx_byte[%0d]: got %02h, expected %02h", pkt_idx - 1, bus.tx_data, e);
                        end
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    eop_at_done = eop_pulses;
                    checks++;
                    if (dexp_q.size() == 0) begin
                        fails++;
                        $display("FAIL done: unexpected done pulse, aborted=%0b", bus.aborted);
                    end else begin
                        de = dexp_q.pop_front();
                        if (bus.aborted !== de.aborted) begin
                            fails++;
                            $display("FAIL aborted: got %0b, expected %0b", bus.aborted, de.aborted);
                        end
                        checks++;
                        if (exp_q.size() != 0) begin
                            fails++;
                            $display("FAIL done_early: got done with %0d bytes outstanding, expected 0", exp_q.size());
                        end
                        checks++;
                        if (bus.busy !== 1'b0) begin
                            fails++;
                            $display("FAIL busy_at_done: got %0b, expected 0", bus.busy);
                        end
                        if (de.crc && !de.aborted) begin
                            checks++;
                            if (res_crc !== 16'hB001) begin
                                fails++;
                                $display("FAIL crc_residual: got %04h, expected b001", res_crc);
                            end
                        end
                        $display("packet done: %0d bytes accepted, aborted=%0b", pkt_idx, bus.aborted);
                    end
                    pkt_idx = 0; res_crc = 16'hFFFF;
                end
                if (bus.generate_eop) eop_pulses++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    // Queues the expected bytes (first keep_n only, all if keep_n<0) and fires start.
    task automatic send(input logic [3:0] p, input int l, input logic c, input int keep_n, input logic ab);
        logic [7:0]  bytes [$];
        logic [15:0] cc;
        bytes.push_back(8'h80);
        bytes.push_back({~p, p});
        cc = 16'hFFFF;
        for (int i = 0; i < l; i++) begin
            bytes.push_back(mem[i]);
            cc = crc_ref(cc, mem[i]);
        end
        if (c) begin
            bytes.push_back(~cc[7:0]);
            bytes.push_back(~cc[15:8]);
        end
        for (int i = 0; i < bytes.size(); i++) begin
            if (keep_n < 0 || i < keep_n) exp_q.push_back(bytes[i]);
        end
        dexp_q.push_back(done_exp_t'{aborted: ab, crc: c});
        bus.pid = p; bus.len = l[AW:0]; bus.crc_en = c; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        checks++;
        if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h80 && bus.busy === 1'b1)) begin
            fails++;
            $display("FAIL first_valid: got valid=%0b data=%02h busy=%0b, expected 1/80/1",
                     bus.tx_valid, bus.tx_data, bus.busy);
        end
    endtask

    task automatic wait_done(input int budget);
        int base, n;
        base = done_cnt; n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge usb_clk);
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles, expected one", budget);
            exp_q.delete(); dexp_q.delete();
        end
        tick(2);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge usb_clk); #1;
            n++;
        end while (acc_cnt < target && n < budget);
        checks++;
        if (acc_cnt < target) begin
            fails++;
            $display("FAIL accept_timeout: got %0d accepts, expected %0d", acc_cnt, target);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBUF; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, l;
        bus.start = 1'b0; bus.pid = '0; bus.len = '0; bus.crc_en = 1'b0;
        bus.keepalive = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < NBUF; i++) mem[i] = 8'h00;
        tick(3);
        checks++;
        if ({bus.tx_valid, bus.tx_data, bus.generate_eop, bus.busy, bus.done, bus.aborted, bus.rd_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%0b data=%02h eop=%0b busy=%0b done=%0b ab=%0b addr=%0d, expected all 0",
                     bus.tx_valid, bus.tx_data, bus.generate_eop, bus.busy, bus.done, bus.aborted, bus.rd_addr);
        end
        usb_rst = 1'b0;
        tick(2);

        // zero-length DATA packet, then a short one with known payload
        send(4'h3, 0, 1'b1, -1, 1'b0);
        wait_done(400);
        mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
        send(4'hB, 4, 1'b1, -1, 1'b0);
        wait_done(400);

        // abort while idle must not affect the next packet
        bus.abort = 1'b1; tick(1); bus.abort = 1'b0; tick(1);
        mem[0] = 8'h15; mem[1] = 8'h07;
        send(4'h9, 2, 1'b0, -1, 1'b0);
        wait_done(400);

        // full-size payload, buffer holds its own address
        for (int i = 0; i < NBUF; i++) mem[i] = 8'(i);
        send(4'hC, NBUF, 1'b1, -1, 1'b0);
        wait_done(2000);
        checks++;
        if (bus.rd_addr !== '0) begin
            fails++;
            $display("FAIL rd_addr_wrap: got %0d, expected 0", bus.rd_addr);
        end

        // abort while the 3rd payload byte is in flight
        fill_random();
        base = acc_cnt;
        send(4'h3, 8, 1'b1, 5, 1'b1);
        wait_acc(base + 4, 200);
        bus.abort = 1'b1; tick(1); bus.abort = 1'b0;
        wait_done(400);
        send(4'hB, 8, 1'b1, -1, 1'b0);
        wait_done(400);

        // keep-alive with start, keep-alive and a stray start mid-packet
        fill_random();
        base = eop_pulses;
        bus.keepalive = 1'b1;
        send(4'hD, 10, 1'b1, -1, 1'b0);
        bus.keepalive = 1'b0;
        wait_acc(acc_cnt + 5, 200);
        bus.keepalive = 1'b1; bus.start = 1'b1; bus.pid = 4'h7; bus.len = 7'd3;
        tick(1);
        bus.keepalive = 1'b0; bus.start = 1'b0;
        wait_done(600);
        checks++;
        if (eop_at_done !== base) begin
            fails++;
            $display("FAIL eop_during_packet: got %0d pulses, expected %0d", eop_at_done - base, 0);
        end
        tick(40);
        checks++;
        if (eop_pulses !== base + 1) begin
            fail_eop: begin
                fails++;
                $display("FAIL keepalive_once: got %0d pulses, expected 1", eop_pulses - base);
            end
        end

        // stand-alone keep-alive from idle
        base = eop_pulses;
        bus.keepalive = 1'b1; tick(1); bus.keepalive = 1'b0;
        tick(30);
        checks++;
        if (eop_pulses !== base + 1) begin
            fails++;
            $display("FAIL keepalive_idle: got %0d pulses, expected 1", eop_pulses - base);
        end

        // reset in the middle of the payload
        fill_random();
        send(4'h3, 20, 1'b1, -1, 1'b0);
        wait_acc(acc_cnt + 6, 200);
        @(posedge usb_clk); #3;
        usb_rst = 1'b1;
        #1;
        checks++;
        if ({bus.tx_valid, bus.tx_data, bus.generate_eop, bus.busy, bus.done, bus.aborted, bus.rd_addr} !== '0) begin
            fails++;
            $display("FAIL reset_async: got valid=%0b data=%02h busy=%0b addr=%0d, expected all 0",
                     bus.tx_valid, bus.tx_data, bus.busy, bus.rd_addr);
        end
        exp_q.delete(); dexp_q.delete();
        tick(2);
        @(negedge usb_clk);
        usb_rst = 1'b0;
        tick(2);
        send(4'hB, 5, 1'b1, -1, 1'b0);
        wait_done(400);

        // randomised packets
        for (int k = 0; k < 10; k++) begin
            fill_random();
            l = ($urandom_range(0, 3) == 0) ? NBUF : int'($urandom_range(0, NBUF));
            send(4'($urandom_range(0, 15)), l, 1'($urandom_range(0, 1)), -1, 1'b0);
            wait_done(2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
